// File: rtl/friscv_mem_rd_arbiter.sv
// Two-port AXI4 read arbiter (icache s0, dcache s1); FRISCV_ARB_FIXED_PRIO_EN selects fixed s1 priority instead of round-robin.
// Latency: AR one cycle through a one-deep output register, R routed combinationally by S1_ID_MASK.
// Backpressure: m_arready low holds the AR register; full outstanding counters hold arready low; m_rready follows the routed port.
module friscv_mem_rd_arbiter #(
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_ID_W    = 8,
  parameter int AXI_DATA_W  = 128,
  parameter int OSTDREQ_NUM = 4,
  parameter int S1_ID_MASK  = 'h20
) (
  input  logic                  aclk,
  input  logic                  srst,
  // s0: instruction cache
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [AXI_ADDR_W-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [AXI_ID_W-1:0]   s0_arid,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [AXI_DATA_W-1:0] s0_rdata,
  output logic [AXI_ID_W-1:0]   s0_rid,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  // s1: data cache
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [AXI_ADDR_W-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [AXI_ID_W-1:0]   s1_arid,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [AXI_DATA_W-1:0] s1_rdata,
  output logic [AXI_ID_W-1:0]   s1_rid,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  // memory side
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [AXI_ADDR_W-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [AXI_ID_W-1:0]   m_arid,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [AXI_DATA_W-1:0] m_rdata,
  input  logic [AXI_ID_W-1:0]   m_rid,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast
);

  localparam int CNT_W = $clog2(OSTDREQ_NUM) + 1;
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(OSTDREQ_NUM);
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [AXI_ID_W-1:0] S1_MASK = AXI_ID_W'(S1_ID_MASK);

  typedef enum logic {
    GNT_S0 = 1'b0,
    GNT_S1 = 1'b1
  } grant_e;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [AXI_ID_W-1:0]   id;
  } ar_t;

  grant_e           last_grant;
  ar_t              ar_q;
  ar_t              ar_d;
  logic             ar_vld_q;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             elig0;
  logic             elig1;
  logic             slot_free;
  logic             gnt0;
  logic             gnt1;
  logic             rsp0_done;
  logic             rsp1_done;
  logic             sel;

  assign elig0     = s0_arvalid && (cnt0 < CNT_MAX);
  assign elig1     = s1_arvalid && (cnt1 < CNT_MAX);
  assign slot_free = !ar_vld_q || m_arready;

  // Reset gates the grant so arready stays low and counters stay cleared while srst is high.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!srst && slot_free) begin
      if (elig0 && elig1) begin
`ifdef FRISCV_ARB_FIXED_PRIO_EN
        gnt1 = 1'b1;
`else
        if (last_grant == GNT_S1) gnt0 = 1'b1;
        else                      gnt1 = 1'b1;
`endif
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end
  end

  assign s0_arready = gnt0;
  assign s1_arready = gnt1;

  always_comb begin
    ar_d = '{addr: s0_araddr, len: s0_arlen, id: s0_arid};
    if (gnt1) ar_d = '{addr: s1_araddr, len: s1_arlen, id: s1_arid};
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      ar_vld_q   <= 1'b0;
      ar_q       <= '0;
      last_grant <= GNT_S1;
    end else if (gnt0 || gnt1) begin
      ar_vld_q   <= 1'b1;
      ar_q       <= ar_d;
      last_grant <= gnt1 ? GNT_S1 : GNT_S0;
    end else if (slot_free) begin
      ar_vld_q   <= 1'b0;
    end
  end

  assign m_arvalid = ar_vld_q;
  assign m_araddr  = ar_q.addr;
  assign m_arlen   = ar_q.len;
  assign m_arid    = ar_q.id;
  assign m_arsize  = 3'($clog2(AXI_DATA_W / 8));
  assign m_arburst = 2'b01;

  // Response routing: any S1 mask bit in the ID steers the beat to the data cache.
  assign sel       = |(m_rid & S1_MASK);
  assign s0_rvalid = m_rvalid && !sel;
  assign s1_rvalid = m_rvalid && sel;
  assign m_rready  = sel ? s1_rready : s0_rready;
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rid    = m_rid;
  assign s1_rid    = m_rid;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;

  assign rsp0_done = s0_rvalid && s0_rready && s0_rlast;
  assign rsp1_done = s1_rvalid && s1_rready && s1_rlast;

  // A stray rlast after a mid-burst reset must not underflow the counter.
  always_ff @(posedge aclk) begin
    if (srst) begin
      cnt0 <= '0;
    end else begin
      case ({gnt0, rsp0_done})
        2'b10:   cnt0 <= cnt0 + CNT_ONE;
        2'b01:   if (cnt0 != '0) cnt0 <= cnt0 - CNT_ONE;
        default: cnt0 <= cnt0;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      cnt1 <= '0;
    end else begin
      case ({gnt1, rsp1_done})
        2'b10:   cnt1 <= cnt1 + CNT_ONE;
        2'b01:   if (cnt1 != '0) cnt1 <= cnt1 - CNT_ONE;
        default: cnt1 <= cnt1;
      endcase
    end
  end

endmodule

// File: tb/tb_friscv_mem_rd_arbiter.sv
// Randomized and directed bench for friscv_mem_rd_arbiter against a cycle-level reference model.
module tb_friscv_mem_rd_arbiter;

  localparam int OST = 4;
`ifdef FRISCV_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         aclk = 1'b0;
  logic         srst;
  logic         s0_arvalid, s0_arready, s1_arvalid, s1_arready;
  logic [31:0]  s0_araddr, s1_araddr, m_araddr;
  logic [7:0]   s0_arlen, s1_arlen, m_arlen;
  logic [7:0]   s0_arid, s1_arid, m_arid;
  logic         s0_rvalid, s0_rready, s1_rvalid, s1_rready;
  logic [127:0] s0_rdata, s1_rdata, m_rdata;
  logic [7:0]   s0_rid, s1_rid, m_rid;
  logic [1:0]   s0_rresp, s1_rresp, m_rresp;
  logic         s0_rlast, s1_rlast, m_rlast;
  logic         m_arvalid, m_arready, m_rvalid, m_rready;
  logic [2:0]   m_arsize;
  logic [1:0]   m_arburst;

  int checks = 0;
  int failures = 0;

  // Reference model state and its next-edge image
  int          mcnt[2];
  int          mlast;
  bit          mv;
  logic [31:0] maddr;
  logic [7:0]  mlen, mid;
  int          n_cnt[2];
  int          n_last;
  bit          n_mv;
  logic [31:0] n_addr;
  logic [7:0]  n_len, n_id;

  always #5 aclk = ~aclk;

  friscv_mem_rd_arbiter dut (
    .aclk(aclk), .srst(srst),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_arlen(s0_arlen), .s0_arid(s0_arid),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata),
    .s0_rid(s0_rid), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_arlen(s1_arlen), .s1_arid(s1_arid),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata),
    .s1_rid(s1_rid), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arid(m_arid), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mcnt[0] = 0; mcnt[1] = 0; mlast = 1; mv = 1'b0;
    maddr = '0; mlen = '0; mid = '0;
  endtask

  task automatic set_idle();
    s0_arvalid = 0; s0_araddr = '0; s0_arlen = '0; s0_arid = '0; s0_rready = 0;
    s1_arvalid = 0; s1_araddr = '0; s1_arlen = '0; s1_arid = 8'h20; s1_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rid = '0; m_rresp = '0; m_rlast = 0;
  endtask

  // Settle combinational outputs, check them, and compute the model's next state.
  task automatic comb_phase();
    bit slot, e0, e1, sel;
    int win;
    #2;
    sel = (m_rid & 8'h20) != 0;
    chk("s0_rvalid", s0_rvalid, m_rvalid && !sel);
    chk("s1_rvalid", s1_rvalid, m_rvalid && sel);
    chk("m_rready", m_rready, sel ? s1_rready : s0_rready);
    chk("s0_rdata", s0_rdata, m_rdata);
    chk("s1_rdata", s1_rdata, m_rdata);
    chk("s1_rid", s1_rid, m_rid);
    chk("s0_rresp", s0_rresp, m_rresp);
    chk("s1_rlast", s1_rlast, m_rlast);
    n_cnt[0] = mcnt[0]; n_cnt[1] = mcnt[1]; n_last = mlast; n_mv = mv;
    n_addr = maddr; n_len = mlen; n_id = mid;
    if (srst) begin
      chk("rst_s0_arready", s0_arready, 1'b0);
      chk("rst_s1_arready", s1_arready, 1'b0);
      n_cnt[0] = 0; n_cnt[1] = 0; n_last = 1; n_mv = 0;
      n_addr = '0; n_len = '0; n_id = '0;
    end else begin
      slot = !mv || m_arready;
      e0 = s0_arvalid && (mcnt[0] < OST);
      e1 = s1_arvalid && (mcnt[1] < OST);
      win = -1;
      if (slot) begin
        if (e0 && e1)  win = FIXED ? 1 : ((mlast == 1) ? 0 : 1);
        else if (e0)   win = 0;
        else if (e1)   win = 1;
      end
      chk("s0_arready", s0_arready, win == 0);
      chk("s1_arready", s1_arready, win == 1);
      if (win == 0) begin
        n_mv = 1; n_addr = s0_araddr; n_len = s0_arlen; n_id = s0_arid; n_last = 0; n_cnt[0]++;
      end else if (win == 1) begin
        n_mv = 1; n_addr = s1_araddr; n_len = s1_arlen; n_id = s1_arid; n_last = 1; n_cnt[1]++;
      end else if (slot) begin
        n_mv = 0;
      end
      if (m_rvalid && !sel && s0_rready && m_rlast && n_cnt[0] > 0) n_cnt[0]--;
      if (m_rvalid && sel && s1_rready && m_rlast && n_cnt[1] > 0) n_cnt[1]--;
    end
  endtask

  // Advance one clock, commit the model and check the registered AR outputs.
  task automatic edge_phase();
    @(posedge aclk);
    #1;
    mcnt[0] = n_cnt[0]; mcnt[1] = n_cnt[1]; mlast = n_last; mv = n_mv;
    maddr = n_addr; mlen = n_len; mid = n_id;
    chk("m_arvalid", m_arvalid, mv);
    chk("m_araddr", m_araddr, maddr);
    chk("m_arlen", m_arlen, mlen);
    chk("m_arid", m_arid, mid);
    chk("m_arsize", m_arsize, 3'd4);
    chk("m_arburst", m_arburst, 2'b01);
  endtask

  task automatic cycle();
    comb_phase();
    edge_phase();
  endtask

  task automatic do_reset();
    srst = 1;
    cycle();
    cycle();
    srst = 0;
  endtask

  task automatic rand_inputs();
    logic [7:0] ids [4];
    ids[0] = 8'h01; ids[1] = 8'h21; ids[2] = 8'h02; ids[3] = 8'h23;
    srst       = ($urandom_range(0, 199) == 0);
    s0_arvalid = ($urandom_range(0, 99) < 60);
    s0_araddr  = $urandom;
    s0_arlen   = 8'($urandom);
    s0_arid    = 8'($urandom) & 8'hDF;
    s1_arvalid = ($urandom_range(0, 99) < 60);
    s1_araddr  = $urandom;
    s1_arlen   = 8'($urandom);
    s1_arid    = 8'($urandom) | 8'h20;
    m_arready  = ($urandom_range(0, 99) < 70);
    m_rvalid   = ($urandom_range(0, 99) < 50);
    m_rid      = ids[$urandom_range(0, 3)];
    m_rlast    = ($urandom_range(0, 99) < 30);
    m_rresp    = 2'($urandom);
    m_rdata    = {$urandom, $urandom, $urandom, $urandom};
    s0_rready  = ($urandom_range(0, 99) < 70);
    s1_rready  = ($urandom_range(0, 99) < 70);
  endtask

  initial begin
    logic [7:0] ids_seen [4];
    logic [7:0] ids_exp [4];

    set_idle();
    srst = 1;
    model_reset();
    @(posedge aclk);
    @(posedge aclk);
    #1;

    // Reset, with a request pending to confirm arready stays low
    s0_arvalid = 1;
    do_reset();
    chk("rst_m_arvalid", m_arvalid, 1'b0);
    chk("rst_m_araddr", m_araddr, 32'h0);

    // Single request and its four-beat response
    s0_araddr = 32'h100; s0_arlen = 8'd3; s0_arid = 8'h01; m_arready = 1;
    comb_phase();
    chk("single_s0_arready", s0_arready, 1'b1);
    edge_phase();
    chk("single_m_arvalid", m_arvalid, 1'b1);
    chk("single_m_araddr", m_araddr, 32'h100);
    chk("single_m_arlen", m_arlen, 8'd3);
    s0_arvalid = 0;
    m_rvalid = 1; m_rid = 8'h01; s0_rready = 1;
    for (int b = 0; b < 4; b++) begin
      m_rlast = (b == 3);
      m_rdata = {4{32'(b) + 32'hA5A5_0000}};
      comb_phase();
      chk("single_s1_rvalid", s1_rvalid, 1'b0);
      chk("single_s0_rvalid", s0_rvalid, 1'b1);
      edge_phase();
    end
    set_idle();

    // Tie between both ports
    do_reset();
    s0_arvalid = 1; s0_arid = 8'h01; s1_arvalid = 1; s1_arid = 8'h21; m_arready = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      ids_seen[i] = m_arid;
      ids_exp[i]  = FIXED ? 8'h21 : ((i % 2 == 0) ? 8'h01 : 8'h21);
    end
    for (int i = 0; i < 4; i++) chk("tie_arid_seq", ids_seen[i], ids_exp[i]);
    s1_arvalid = 0;
    comb_phase();
    chk("tie_s0_after_s1_drop", s0_arready, 1'b1);
    edge_phase();
    set_idle();

    // Backpressure holds payload and suppresses grants
    do_reset();
    s0_arvalid = 1; s0_araddr = 32'h100; s0_arid = 8'h01; m_arready = 1;
    cycle();
    s0_araddr = 32'h200; m_arready = 0;
    for (int i = 0; i < 5; i++) begin
      comb_phase();
      chk("bp_no_arready", s0_arready, 1'b0);
      edge_phase();
      chk("bp_addr_stable", m_araddr, 32'h100);
    end
    m_arready = 1;
    comb_phase();
    chk("bp_release_grant", s0_arready, 1'b1);
    edge_phase();
    chk("bp_release_addr", m_araddr, 32'h200);
    set_idle();

    // Outstanding limit on s1
    do_reset();
    s1_arvalid = 1; s1_arid = 8'h21; m_arready = 1;
    for (int i = 0; i < 4; i++) cycle();
    s0_arvalid = 1; s0_arid = 8'h02;
    comb_phase();
    chk("ost_s1_blocked", s1_arready, 1'b0);
    chk("ost_s0_granted", s0_arready, 1'b1);
    edge_phase();
    s0_arvalid = 0;
    m_rvalid = 1; m_rid = 8'h21; m_rlast = 1; s1_rready = 1;
    comb_phase();
    chk("ost_s1_still_blocked", s1_arready, 1'b0);
    edge_phase();
    m_rvalid = 0;
    comb_phase();
    chk("ost_s1_regranted", s1_arready, 1'b1);
    edge_phase();
    set_idle();

    // Interleaved R with s0 stalled, then reset mid-burst
    s0_rready = 0; s1_rready = 1; m_rvalid = 1; s0_arvalid = 1; m_arready = 1;
    for (int i = 0; i < 4; i++) begin
      m_rid = (i % 2 == 0) ? 8'h21 : 8'h02;
      m_rlast = (i == 3);
      comb_phase();
      chk("intl_m_rready", m_rready, (i % 2 == 0) ? 1'b1 : 1'b0);
      edge_phase();
    end
    srst = 1;
    cycle();
    chk("midrst_m_arvalid", m_arvalid, 1'b0);
    srst = 0;
    set_idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/friscv_mem_rd_arbiter.md
Name: friscv_mem_rd_arbiter

Overview:
- Shares the single AXI4 read master toward central memory between two requesters: port s0 (instruction cache) and port s1 (data cache).
- AR channel: round-robin arbitration feeding a one-deep output register. Per-port outstanding counters bound in-flight bursts.
- R channel: routed back by ID mask bits.
- Sits between the cache read masters and the memory interconnect.

Parameters:
- AXI_ADDR_W, 32: address width, all ports.
- AXI_ID_W, 8: ID width, all ports.
- AXI_DATA_W, 128: read data width, all ports.
- OSTDREQ_NUM, 4: max outstanding bursts per port (power of 2, ≥1).
- S1_ID_MASK, 'h20: ID bits identifying s1 traffic. Any response with a matching bit goes to s1, otherwise to s0.

Ports:
- aclk  in  1  clock, all logic rising-edge.
- srst  in  1  synchronous active-high reset.
- sX_arvalid  in  1  read request valid, X=0,1.
- sX_arready  out  1  request accepted, X=0,1.
- sX_araddr  in  AXI_ADDR_W  request address, X=0,1.
- sX_arlen  in  8  burst length-1, X=0,1.
- sX_arid  in  AXI_ID_W  request ID (s1 IDs carry S1_ID_MASK, s0 IDs never do), X=0,1.
- sX_rvalid  out  1  response beat valid, X=0,1.
- sX_rready  in  1  response beat accepted, X=0,1.
- sX_rdata / sX_rid / sX_rresp / sX_rlast  out  AXI_DATA_W / AXI_ID_W / 2 / 1  response beat payload, X=0,1.
- m_arvalid  out  1  memory request valid.
- m_arready  in  1  memory request accepted.
- m_araddr / m_arlen / m_arid  out  AXI_ADDR_W / 8 / AXI_ID_W  registered request payload.
- m_arsize  out  3  constant $clog2(AXI_DATA_W/8).
- m_arburst  out  2  constant 2'b01 (INCR).
- m_rvalid  in  1  memory response valid.
- m_rready  out  1  memory response ready.
- m_rdata / m_rid / m_rresp / m_rlast  in  AXI_DATA_W / AXI_ID_W / 2 / 1  memory response payload.

Behaviour:
- Reset (srst=1 at a clock edge):
  - m_arvalid=0, m_araddr/m_arlen/m_arid=0.
  - s0_arready=s1_arready=0.
  - Both outstanding counters=0.
  - Round-robin pointer last_grant=s1, so s0 wins the first tie.
  - Reset mid-burst drops all state. Any in-flight response is the system's responsibility.
- Eligibility: port X is eligible when sX_arvalid=1 and cnt_X < OSTDREQ_NUM.
- Output slot free: slot_free = !m_arvalid | m_arready.
- Grant (combinational, evaluated only when slot_free):
  - Only one port eligible: that port wins.
  - Both eligible: the port != last_grant wins.
- On grant to X:
  - sX_arready=1 this cycle. The other port's arready=0. arready is never asserted without a grant.
  - Next edge: m_araddr/m_arlen/m_arid <= sX payload, m_arvalid <= 1, last_grant <= X, cnt_X increments.
- No grant while slot_free: m_arvalid clears on the m_arready edge.
- Latency and throughput:
  - Exactly 1 cycle from sX_arvalid&sX_arready to m_arvalid.
  - Back-to-back throughput of one request per cycle while m_arready stays high.
- m_ar payload stays stable while m_arvalid=1 and m_arready=0 (AXI compliant).
- Counter decrement: cnt_X decrements on sX_rvalid & sX_rready & sX_rlast.
  - Increment and decrement in the same cycle: cnt_X unchanged.
  - Counters never wrap. Width is $clog2(OSTDREQ_NUM)+1.
- R routing (combinational, zero latency):
  - sel = |(m_rid & S1_ID_MASK).
  - s1_rvalid = m_rvalid & sel; s0_rvalid = m_rvalid & !sel.
  - m_rready = sel ? s1_rready : s0_rready.
  - rdata/rid/rresp/rlast are broadcast to both ports unmodified.
- AR and R paths are independent. A response may complete in the same cycle as a new grant to the same port.

Optional Feature:
- Macro: FRISCV_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, s1 (data cache) always wins when both ports are eligible. last_grant is still tracked but ignored.
- Undefined: round-robin as described above.
- Counter, latency and routing rules are identical in both modes.

Test Plan:
- Single request: after reset, s0 requests araddr=0x100, arlen=3, arid=0x01 → s0_arready pulses in cycle 0 and m_arvalid=1 with the same payload in cycle 1. Four R beats with m_rid=0x01 appear only on s0; cnt_0 returns to 0 after rlast.
- Tie, round-robin: both ports hold arvalid with m_arready=1 → grants alternate s0,s1,s0,s1. m_arid sequence is 0x01,0x21,0x01,0x21.
- Tie, fixed priority: same stimulus with FRISCV_ARB_FIXED_PRIO_EN defined → all grants go to s1 until s1_arvalid drops, then s0 is served.
- Backpressure: m_arready=0 for 5 cycles with m_arvalid=1 → payload stable and no sX_arready pulse. On release, the next grant is issued in the same cycle as the handshake.
- Outstanding limit: s1 issues 4 requests with no responses (OSTDREQ_NUM=4) → fifth is blocked (s1_arready=0) while s0 is still granted. One s1 rlast handshake → s1 is granted on the next eligible cycle.
- Interleaved R and reset: R beats with m_rid=0x21 and 0x02 interleaved and s0_rready=0 → m_rready follows the selected port's ready. srst mid-burst → counters=0, m_arvalid=0 at the next edge.
